// File: rtl/csr_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// csr_access_unit_pkg
// Shared definitions for the Zicsr access sequencer:
//   - MXLEN_DEFAULT : default CSR/data width
//   - F3_*          : Zicsr funct3 encodings
//   - state_t       : sequencer FSM state encoding
//   - funct3_is_bad : true for the two funct3 values that are not Zicsr ops
//
// Handshake rule used by the unit on both req_* and resp_*: a transfer happens
// on the rising CLK edge where valid && ready are both 1; the sender holds its
// payload stable while valid is 1 and ready is 0.
// -----------------------------------------------------------------------------
package csr_access_unit_pkg;

    localparam int MXLEN_DEFAULT = 32;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // funct3 000 and 100 fall in the Zicsr opcode space but are not CSR ops.
    function automatic logic funct3_is_bad(input logic [2:0] funct3);
        return (funct3[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/csr_access_unit_wdata_gen.sv
// -----------------------------------------------------------------------------
// csr_wdata_gen
// Purely combinational write-value generator for one Zicsr access.
// Ports:
//   funct3       in   3      instruction funct3
//   rs1          in   5      rs1 index, or zimm for the immediate forms
//   rs1_data     in   MXLEN  rs1 register value
//   old          in   MXLEN  current CSR value
//   addr         in   12     CSR address (for the read-only check)
//   wdata        out  MXLEN  new CSR value
//   do_write     out  1      the instruction writes the CSR
//   ro_violation out  1      a write is attempted on a read-only CSR
// -----------------------------------------------------------------------------
module csr_wdata_gen
    import csr_access_unit_pkg::*;
#(
    parameter int MXLEN = MXLEN_DEFAULT
) (
    input  logic [2:0]       funct3,
    input  logic [4:0]       rs1,
    input  logic [MXLEN-1:0] rs1_data,
    input  logic [MXLEN-1:0] old,
    input  logic [11:0]      addr,
    output logic [MXLEN-1:0] wdata,
    output logic             do_write,
    output logic             ro_violation
);

    logic [MXLEN-1:0] w_src;

    // Immediate forms take the 5-bit field itself, zero-extended.
    assign w_src = funct3[2] ? {{(MXLEN-5){1'b0}}, rs1} : rs1_data;

    always_comb begin
        wdata    = '0;
        do_write = 1'b0;
        case (funct3[1:0])
            2'b01: begin
                wdata    = w_src;
                do_write = 1'b1;
            end
            2'b10: begin
                wdata    = old | w_src;
                do_write = (rs1 != 5'd0);
            end
            2'b11: begin
                wdata    = old & ~w_src;
                do_write = (rs1 != 5'd0);
            end
            default: begin
                wdata    = '0;
                do_write = 1'b0;
            end
        endcase
    end

    // addr[11:10] == 2'b11 marks the read-only CSR space.
    assign ro_violation = do_write && (addr[11:10] == 2'b11);

endmodule

// File: rtl/csr_access_unit.sv
// -----------------------------------------------------------------------------
// csr_access_unit
// Executes one Zicsr instruction at a time against the machine-mode CSR file:
// read (combinational port), compute, optional single-cycle write, respond
// with the old value. Fixed 3-cycle latency from acceptance to response.
// Ports:
//   CLK, reset_n                 clock, asynchronous active-low reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_addr/funct3/rs1/rs1_data request payload, sampled on acceptance
//   csr_addr                     CSR address, held from the latched request
//   csr_rdata, csr_rd_err        combinational read data / nonexistent CSR
//   csr_wr_en, csr_wdata         one-cycle write strobe and data
//   resp_valid/resp_ready        response handshake
//   resp_data, resp_illegal      old CSR value (0 if illegal), exception flag
// -----------------------------------------------------------------------------
module csr_access_unit
    import csr_access_unit_pkg::*;
#(
    parameter int MXLEN = MXLEN_DEFAULT
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [11:0]      req_addr,
    input  logic [2:0]       req_funct3,
    input  logic [4:0]       req_rs1,
    input  logic [MXLEN-1:0] req_rs1_data,
    output logic [11:0]      csr_addr,
    input  logic [MXLEN-1:0] csr_rdata,
    input  logic             csr_rd_err,
    output logic             csr_wr_en,
    output logic [MXLEN-1:0] csr_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [MXLEN-1:0] resp_data,
    output logic             resp_illegal
);

    state_t           r_state;
    state_t           w_next_state;

    logic [11:0]      r_addr;
    logic [2:0]       r_funct3;
    logic [4:0]       r_rs1;
    logic [MXLEN-1:0] r_rs1_data;
    logic [MXLEN-1:0] r_old;
    logic             r_illegal;
    logic [MXLEN-1:0] r_wdata;
    logic [MXLEN-1:0] r_resp_data;
    logic             r_resp_illegal;

    logic [MXLEN-1:0] w_wdata;
    logic             w_do_write;
    logic             w_ro_violation;

    // In READ the generator sees the live CSR value; do_write depends only on
    // the latched funct3/rs1, so the same output is still valid in WRITE.
    csr_wdata_gen #(
        .MXLEN        (MXLEN)
    ) u_wdata_gen (
        .funct3       (r_funct3),
        .rs1          (r_rs1),
        .rs1_data     (r_rs1_data),
        .old          (csr_rdata),
        .addr         (r_addr),
        .wdata        (w_wdata),
        .do_write     (w_do_write),
        .ro_violation (w_ro_violation)
    );

    // ---------------------------------------------------------------- state
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (req_valid) w_next_state = ST_READ;
            ST_READ:  w_next_state = ST_WRITE;
            ST_WRITE: w_next_state = ST_RESP;
            ST_RESP:  if (resp_ready) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Decoded straight from r_state so an asynchronous reset drops the write
    // strobe and the response immediately.
    always_comb begin
        req_ready  = 1'b0;
        csr_wr_en  = 1'b0;
        resp_valid = 1'b0;
        case (r_state)
            ST_IDLE:  req_ready  = 1'b1;
            ST_WRITE: csr_wr_en  = w_do_write && !r_illegal;
            ST_RESP:  resp_valid = 1'b1;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_addr         <= '0;
            r_funct3       <= '0;
            r_rs1          <= '0;
            r_rs1_data     <= '0;
            r_old          <= '0;
            r_illegal      <= 1'b0;
            r_wdata        <= '0;
            r_resp_data    <= '0;
            r_resp_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr     <= req_addr;
                        r_funct3   <= req_funct3;
                        r_rs1      <= req_rs1;
                        r_rs1_data <= req_rs1_data;
                    end
                end
                ST_READ: begin
                    r_old     <= csr_rdata;
                    r_wdata   <= w_wdata;
                    r_illegal <= funct3_is_bad(r_funct3) || csr_rd_err
                                 || w_ro_violation;
                end
                ST_WRITE: begin
                    r_resp_data    <= r_illegal ? '0 : r_old;
                    r_resp_illegal <= r_illegal;
                end
                default: ;
            endcase
        end
    end

    assign csr_addr     = r_addr;
    assign csr_wdata    = r_wdata;
    assign resp_data    = r_resp_data;
    assign resp_illegal = r_resp_illegal;

endmodule

// File: tb/tb_csr_access_unit.sv
module tb_csr_access_unit;

  localparam int W = 32;

  logic          CLK;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic [11:0]   req_addr;
  logic [2:0]    req_funct3;
  logic [4:0]    req_rs1;
  logic [W-1:0]  req_rs1_data;
  logic [11:0]   csr_addr;
  logic [W-1:0]  csr_rdata;
  logic          csr_rd_err;
  logic          csr_wr_en;
  logic [W-1:0]  csr_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [W-1:0]  resp_data;
  logic          resp_illegal;

  int n_vec = 0;
  int n_err = 0;

  // environment CSR file (what the DUT talks to)
  logic [W-1:0]  csr_mem [4096];
  // reference copy, updated only by the model
  logic [W-1:0]  ref_mem [4096];
  // observed write strobes {addr, data}
  logic [11+W:0] wr_q [$];

  csr_access_unit #(.MXLEN(W)) dut (
    .CLK          (CLK),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_funct3   (req_funct3),
    .req_rs1      (req_rs1),
    .req_rs1_data (req_rs1_data),
    .csr_addr     (csr_addr),
    .csr_rdata    (csr_rdata),
    .csr_rd_err   (csr_rd_err),
    .csr_wr_en    (csr_wr_en),
    .csr_wdata    (csr_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_illegal (resp_illegal)
  );

  // ---------------------------------------------------------- clock block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------- CSR file model
  function automatic logic is_err_addr(input logic [11:0] a);
    return (a[11:4] == 8'h7C);
  endfunction

  assign csr_rdata  = csr_mem[csr_addr];
  assign csr_rd_err = is_err_addr(csr_addr);

  always @(posedge CLK) begin
    if (csr_wr_en === 1'b1) begin
      wr_q.push_back({csr_addr, csr_wdata});
      csr_mem[csr_addr] <= csr_wdata;
    end
  end

  // ---------------------------------------------------------- checking
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_csr(input logic [11:0] a, input logic [W-1:0] v);
    csr_mem[a] = v;
    ref_mem[a] = v;
  endtask

  // Reference: Zicsr semantics straight from the instruction definitions.
  task automatic ref_exec(input logic [11:0] a, input logic [2:0] f3,
                          input logic [4:0] rs1, input logic [W-1:0] d,
                          output logic [W-1:0] e_resp, output logic e_ill,
                          output logic e_wr, output logic [W-1:0] e_wd);
    logic [W-1:0] old_v, src, nv;
    logic writes, bad;
    old_v = ref_mem[a];
    src   = f3[2] ? W'(rs1) : d;
    bad   = 1'b0;
    case (f3)
      3'b001, 3'b101: begin writes = 1'b1;        nv = src;          end
      3'b010, 3'b110: begin writes = (rs1 != 0);  nv = old_v | src;  end
      3'b011, 3'b111: begin writes = (rs1 != 0);  nv = old_v & ~src; end
      default:        begin writes = 1'b0; nv = '0; bad = 1'b1;      end
    endcase
    e_ill  = bad || is_err_addr(a) || (writes && a >= 12'hC00);
    e_wr   = writes && !e_ill;
    e_wd   = nv;
    e_resp = e_ill ? '0 : old_v;
    if (e_wr) ref_mem[a] = nv;
  endtask

  // ------------------------------------------------------- driver tasks
  task automatic run_txn(input logic [11:0] a, input logic [2:0] f3,
                         input logic [4:0] rs1, input logic [W-1:0] d,
                         input int stall);
    logic [W-1:0]  e_resp, e_wd;
    logic          e_ill, e_wr;
    logic [11+W:0] w;
    ref_exec(a, f3, rs1, d, e_resp, e_ill, e_wr, e_wd);
    wr_q.delete();
    @(negedge CLK);
    req_valid = 1'b1; req_addr = a; req_funct3 = f3; req_rs1 = rs1; req_rs1_data = d;
    chk("req_ready_idle", W'(req_ready), 1);
    @(posedge CLK); #1;
    // scramble the request bus; the unit must ignore it until IDLE
    req_valid    = 1'($urandom_range(0, 1));
    req_addr     = 12'($urandom);
    req_funct3   = 3'($urandom);
    req_rs1      = 5'($urandom);
    req_rs1_data = $urandom;
    @(negedge CLK);
    chk("read_resp_valid", W'(resp_valid), 0);
    chk("read_req_ready", W'(req_ready), 0);
    chk("read_csr_addr", W'(csr_addr), W'(a));
    @(negedge CLK);
    chk("write_csr_addr", W'(csr_addr), W'(a));
    chk("write_wr_en", W'(csr_wr_en), W'(e_wr));
    if (e_wr) chk("write_wdata", csr_wdata, e_wd);
    @(negedge CLK);
    chk("resp_valid_lat3", W'(resp_valid), 1);
    chk("resp_data", resp_data, e_resp);
    chk("resp_illegal", W'(resp_illegal), W'(e_ill));
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      @(negedge CLK);
      chk("stall_resp_valid", W'(resp_valid), 1);
      chk("stall_resp_data", resp_data, e_resp);
      chk("stall_resp_illegal", W'(resp_illegal), W'(e_ill));
      chk("stall_req_ready", W'(req_ready), 0);
      chk("stall_wr_en", W'(csr_wr_en), 0);
    end
    resp_ready = 1'b1;
    req_valid  = 1'b0;
    @(posedge CLK); #1;
    resp_ready = 1'b0;
    chk("post_resp_valid", W'(resp_valid), 0);
    chk("post_req_ready", W'(req_ready), 1);
    chk("wr_count", W'(wr_q.size()), e_wr ? 1 : 0);
    if (wr_q.size() > 0) begin
      w = wr_q.pop_front();
      chk("wr_addr", W'(w[11+W:W]), W'(a));
      chk("wr_data", w[W-1:0], e_wd);
    end
    wr_q.delete();
  endtask

  // ------------------------------------------------------ stimulus
  logic [11:0] pool [8];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      csr_mem[i] = '0;
      ref_mem[i] = '0;
    end
    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_funct3 = '0;
    req_rs1 = '0; req_rs1_data = '0; resp_ready = 1'b0;
    #1;
    chk("rst_req_ready", W'(req_ready), 1);
    chk("rst_wr_en", W'(csr_wr_en), 0);
    chk("rst_resp_valid", W'(resp_valid), 0);
    chk("rst_csr_addr", W'(csr_addr), 0);
    chk("rst_csr_wdata", csr_wdata, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_illegal", W'(resp_illegal), 0);
    repeat (2) @(negedge CLK);
    reset_n = 1'b1;
    @(negedge CLK);
    chk("rel_req_ready", W'(req_ready), 1);
    chk("rel_resp_valid", W'(resp_valid), 0);

    // directed cases
    set_csr(12'h340, 32'h12345678);
    run_txn(12'h340, 3'b001, 5'd1, 32'hDEADBEEF, 0);
    set_csr(12'hB00, 32'h00000042);
    run_txn(12'hB00, 3'b010, 5'd0, 32'hFFFFFFFF, 0);
    run_txn(12'hB00, 3'b010, 5'd3, 32'h00000100, 0);
    set_csr(12'hF14, 32'h0);
    run_txn(12'hF14, 3'b011, 5'd5, 32'h0000FFFF, 0);
    run_txn(12'hF14, 3'b010, 5'd0, 32'h0000FFFF, 0);
    set_csr(12'h300, 32'h0000188F);
    run_txn(12'h300, 3'b111, 5'h1F, 32'hFFFFFFFF, 0);
    run_txn(12'h300, 3'b100, 5'd7, 32'h12340000, 0);
    set_csr(12'h7C0, 32'hCAFEF00D);
    run_txn(12'h7C0, 3'b001, 5'd2, 32'h00000001, 0);
    run_txn(12'h7C0, 3'b010, 5'd0, 32'h00000001, 0);
    // backpressure for 5 cycles with a competing request held high
    set_csr(12'h341, 32'hA5A5A5A5);
    run_txn(12'h341, 3'b101, 5'h0A, 32'h0, 5);

    // reset during WRITE: strobe must drop without a clock edge
    wr_q.delete();
    @(negedge CLK);
    req_valid = 1'b1; req_addr = 12'h342; req_funct3 = 3'b001;
    req_rs1 = 5'd4; req_rs1_data = 32'h55AA55AA;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(posedge CLK); #1;
    chk("rstmid_wr_en_before", W'(csr_wr_en), 1);
    reset_n = 1'b0;
    #1;
    chk("rstmid_wr_en_async", W'(csr_wr_en), 0);
    chk("rstmid_resp_valid", W'(resp_valid), 0);
    chk("rstmid_req_ready", W'(req_ready), 1);
    @(negedge CLK);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      chk("rstmid_no_resp", W'(resp_valid), 0);
      chk("rstmid_idle", W'(req_ready), 1);
    end
    chk("rstmid_no_write", W'(wr_q.size()), 0);
    chk("rstmid_mem", csr_mem[12'h342], ref_mem[12'h342]);

    // randomized traffic
    pool[0] = 12'h300; pool[1] = 12'h340; pool[2] = 12'h341; pool[3] = 12'hB00;
    pool[4] = 12'hF11; pool[5] = 12'hC00; pool[6] = 12'h7C3; pool[7] = 12'h305;
    for (int i = 0; i < 8; i++) set_csr(pool[i], $urandom);
    for (int n = 0; n < 60; n++) begin
      logic [11:0] a;
      logic [4:0]  r;
      a = ($urandom_range(0, 9) == 0) ? 12'($urandom) : pool[$urandom_range(0, 7)];
      r = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      run_txn(a, 3'($urandom), r, $urandom, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/csr_access_unit.md
# csr_access_unit

Sequencer that executes Zicsr instructions (CSRRW/S/C and the immediate forms) against the machine-mode CSR file. It sits between decode/execute and the CSR file: it accepts one CSR request over a valid/ready handshake, reads the CSR, computes the new value, issues at most one write, and returns the old value for `rd`. It is the initiator side of the CSR file's combinational read / single-cycle write port.

## Interface
Parameters:
- `MXLEN`, default `` `MXLEN `` (32): CSR and data width.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle and able to accept.
- `req_addr`  in  12  CSR address.
- `req_funct3`  in  3  instruction funct3.
- `req_rs1`  in  5  rs1 index, or zimm for the immediate forms.
- `req_rs1_data`  in  MXLEN  rs1 register value.
- `csr_addr`  out  12  address to the CSR file.
- `csr_rdata`  in  MXLEN  combinational read data from the CSR file.
- `csr_rd_err`  in  1  addressed CSR does not exist; valid the same cycle as `csr_rdata`.
- `csr_wr_en`  out  1  one-cycle write strobe.
- `csr_wdata`  out  MXLEN  write data.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts the response.
- `resp_data`  out  MXLEN  old CSR value, or 0 if the access is illegal.
- `resp_illegal`  out  1  raise an illegal-instruction exception.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1. When `req_valid`, capture addr, funct3, rs1 and rs1_data, then go to READ.
- READ: drive the latched address on `csr_addr`. Latch `csr_rdata` as `old` and `csr_rd_err`. Go to WRITE.
- WRITE: `csr_wr_en`=1 for exactly this cycle when `do_write` is true and the access is not illegal. Go to RESP.
- RESP: `resp_valid`=1. Hold data until `resp_valid && resp_ready`, then go to IDLE.
- Source operand: `src` = funct3[2] ? zero-extended 5-bit zimm : latched rs1_data.
- `do_write`:
  - RW and RWI: always.
  - RS, RC, RSI, RCI: only when the rs1/zimm field ≠ 0.
- Write data by funct3[1:0]:
  - 01: `src`
  - 10: `old | src`
  - 11: `old & ~src`
- Illegal when any of these hold:
  - funct3 ∈ {000, 100};
  - `csr_rd_err` latched in READ;
  - `do_write` and `addr[11:10]==2'b11` (read-only CSR).
- Effect of an illegal access: no write, `resp_data`=0, `resp_illegal`=1.
- A read of a read-only CSR with `do_write`=0 is legal.

## Timing
- Request accepted at edge T. READ covers T..T+1, WRITE covers T+1..T+2. `resp_valid` rises after edge T+2.
- Fixed latency of 3 cycles from acceptance to response. WRITE is always visited.
- `csr_addr` is stable from READ through WRITE and holds its value otherwise.
- Maximum throughput is one request per 4 cycles. `req_ready` is 0 outside IDLE.
- `req_*` inputs are ignored when not in IDLE.
- Backpressure: while `resp_ready`=0, `resp_data` and `resp_illegal` stay stable. No CSR traffic occurs.
- Reset values:
  - state IDLE, so `req_ready`=1 once reset is released;
  - `csr_wr_en`=0, `resp_valid`=0;
  - `csr_addr`=0, `csr_wdata`=0, `resp_data`=0, `resp_illegal`=0.
- Reset mid-operation: asserting `reset_n` low in any state immediately forces `csr_wr_en`=0 and `resp_valid`=0. The in-flight request is dropped with no write and no response.

## Structure
- `defs.v`: add funct3 encodings (CSRRW=001, CSRRS=010, CSRRC=011, CSRRWI=101, CSRRSI=110, CSRRCI=111) and the FSM state encodings. `MXLEN` is already defined there.
- One combinational sub-module, `csr_wdata_gen`. Inputs: funct3, rs1 field, rs1_data, old. Outputs: `wdata`, `do_write`, `ro_violation`.
- The top level holds the FSM and the request/response registers.

## Test plan
- CSRRW 0x340, rs1_data=0xDEADBEEF, CSR holds 0x12345678 → exactly one `csr_wr_en` pulse with wdata 0xDEADBEEF; `resp_data`=0x12345678, `resp_illegal`=0, `resp_valid` 3 cycles after acceptance.
- CSRRS 0xB00 with rs1=0, `csr_rdata`=0x00000042 → no `csr_wr_en`; `resp_data`=0x42. Repeat with rs1=3 and rs1_data=0x100 → wdata 0x142.
- CSRRC 0xF14 with rs1=5 → `resp_illegal`=1, `resp_data`=0, no write. CSRRS 0xF14 with rs1=0 → legal, `resp_data`=0.
- CSRRCI 0x300 with zimm=0x1F, old=0x0000188F → wdata 0x00001880. funct3=100 → illegal, no write. `csr_rd_err`=1 on address 0x7C0 → illegal.
- `resp_ready` held 0 for 5 cycles → `resp_valid`/`resp_data` stable, `req_ready`=0, a concurrent `req_valid` is not accepted, no CSR strobes.
- `reset_n` driven low during WRITE → `csr_wr_en` drops without waiting for a clock edge; after release the unit is in IDLE with `req_ready`=1 and no response ever appears for the dropped request.
